vs_fifo: RTL and testbench
==========================

# vs_fifo

Parametrised valid/stall FIFO that supersedes the power-of-two `fifo` plus its ad-hoc valid/stall wrappers. It is intended for ray-pipeline unit boundaries.
- Accepts words on an upstream valid/stall port and presents them on a downstream valid/stall port with first-word fall-through.
- Depth is arbitrary, not restricted to powers of two.
- Provides an almost-full threshold for early back-pressure to deep pipelines, a synchronous flush, and a peak-occupancy monitor for sizing.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 6, number of storage entries (≥2, any integer)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- us_valid  in  1  upstream word present
- us_data  in  WIDTH  upstream word
- us_stall  out  1  upstream must hold word; equals full & us_valid
- ds_valid  out  1  head word present (= ~empty)
- ds_data  out  WIDTH  head word; 0 when empty
- ds_stall  in  1  downstream refuses head word this cycle
- flush  in  1  synchronous clear of contents and monitor
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count ≥ AF_THRESH
- max_count  out  $clog2(DEPTH+1)  peak occupancy since reset/flush

## Operation
- Push: us_valid & ~full, where full = (count == DEPTH). Writes mem[wptr]; wptr advances.
- Pop: ds_valid & ~ds_stall. rptr advances; the vacated entry is not cleared.
- Pointers run 0..DEPTH-1 and wrap DEPTH-1 → 0 by explicit compare, not modulo-2^k.
- count_n:
  - count+1 on push only
  - count-1 on pop only
  - unchanged on both or neither
- Simultaneous push and pop are legal at any occupancy except:
  - When full: push is refused (us_stall=1) even if a pop occurs. There is no combinational path from ds_stall to us_stall.
  - When empty: pop is impossible (ds_valid=0). A push lands and becomes visible next cycle; there is no bypass.
- flush=1 takes priority over push and pop that cycle:
  - Next cycle: count, rptr, wptr and max_count are 0.
  - Storage is not cleared.
  - An upstream word offered in a flush cycle is dropped; the upstream sees us_stall per current full.
- max_count_n = max(max_count, count_n), updated every non-flush cycle.
- ds_data = mem[rptr] when ds_valid, else 0.

## Timing
- Reset (rst=0), asynchronous:
  - count=0, max_count=0, pointers=0
  - ds_valid=0, ds_data=0, us_stall=0
  - almost_full=0
  - storage zeroed
- Latency: a word pushed at edge N appears on ds_valid/ds_data in the cycle after edge N (1 cycle). Throughput is 1 word/cycle in steady state.
- All status outputs are functions of registered state only:
  - count, almost_full, max_count, ds_valid, ds_data
  - us_stall additionally ANDs the us_valid input
- Handshake: the source holds us_data stable while us_stall=1. ds_data is stable while ds_valid & ds_stall.
- Reset deassertion mid-stream: the FIFO comes out of reset empty. Words in flight are discarded; no partial state survives.

## Structure
- No shared package entries are required. Widths are local parameters derived from DEPTH: PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).
- Storage is a packed register array with asynchronous reset, in the style of ff_ar.
- One sub-module, `wrap_ptr #(DEPTH)`:
  - Enable-driven pointer, 0..DEPTH-1 with wrap.
  - Synchronous clear; asynchronous active-low reset.
  - Instantiated twice, for rptr and wptr.

## Test plan
- Reset then fill: DEPTH=6, WIDTH=8.
  - Push 1..6 with ds_stall=1 → count reaches 6, almost_full from count=4, us_stall=1 on the 7th offer, max_count=6.
  - Release ds_stall → outputs 1..6 in order.
- Non-power-of-two wrap: DEPTH=5.
  - Stream 23 words with random ds_stall → output order matches input exactly.
  - wptr wraps 4→0 at least four times; no word is lost or duplicated.
- Simultaneous push/pop at mid-occupancy: count=3, push and pop for 10 cycles → count stays 3, one word out per cycle.
- Full with pop: count=DEPTH, ds_stall=0, us_valid=1 → us_stall=1 that cycle, count becomes DEPTH-1, push accepted the next cycle.
- Flush: count=4, max_count=5, flush with us_valid=1 → next cycle count=0, ds_valid=0, max_count=0, offered word absent from the output.
- Reset mid-operation: count=3, pull rst low for one cycle → ds_valid=0, ds_data=0, count=0 immediately. Subsequent pushes are output starting from the first new word.

Source files
------------

// File: rtl/vs_fifo_pkg.sv
// rtl/vs_fifo_pkg.sv - shared types for the valid/stall FIFO
package vs_fifo_pkg;

    // Per-cycle occupancy action, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/vs_fifo_wrap_ptr.sv
// rtl/vs_fifo_wrap_ptr.sv - enable-driven pointer counting 0..DEPTH-1 with wrap
module wrap_ptr #(
    parameter int DEPTH = 6,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Advance on enable; wrap by explicit compare so any depth works
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/vs_fifo.sv
// rtl/vs_fifo.sv - first-word fall-through valid/stall FIFO of arbitrary depth
module vs_fifo
    import vs_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 6,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             us_valid,
    input  logic [WIDTH-1:0] us_data,
    output logic             us_stall,
    output logic             ds_valid,
    output logic [WIDTH-1:0] ds_data,
    input  logic             ds_stall,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic [CNT_W-1:0] max_count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wptr;
    logic [PTR_W-1:0]            rptr;
    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    logic [CNT_W-1:0]            count_n;
    fifo_op_e                    op;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Flush wins over both ports; a full FIFO refuses a push even when popping
    assign push = us_valid & ~full & ~flush;
    assign pop  = ~empty & ~ds_stall & ~flush;
    assign op   = fifo_op_e'({push, pop});

    assign us_stall    = full & us_valid;
    assign ds_valid    = ~empty;
    assign ds_data     = ds_valid ? mem[rptr] : '0;
    assign almost_full = (count >= AF_CNT);

    wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (push),
        .ptr (wptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (pop),
        .ptr (rptr)
    );

    // Next occupancy from the combined push/pop action
    always_comb begin
        count_n = count;
        case (op)
            OP_PUSH: count_n = count + 1'b1;
            OP_POP:  count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    // Storage: written at wptr on push, never cleared by pop or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (push) begin
            mem[wptr] <= us_data;
        end
    end

    // Occupancy and peak-occupancy monitor, both cleared by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            max_count <= '0;
        end else if (flush) begin
            count     <= '0;
            max_count <= '0;
        end else begin
            count     <= count_n;
            max_count <= (count_n > max_count) ? count_n : max_count;
        end
    end

endmodule

// File: tb/tb_vs_fifo.sv
// tb/tb_vs_fifo.sv - directed self-checking bench for vs_fifo
module tb_vs_fifo;

    logic       clk = 1'b0;
    logic       rst;

    logic       us_valid;
    logic [7:0] us_data;
    logic       us_stall;
    logic       ds_valid;
    logic [7:0] ds_data;
    logic       ds_stall;
    logic       flush;
    logic [2:0] count;
    logic       almost_full;
    logic [2:0] max_count;

    logic       v5;
    logic [7:0] d5_in;
    logic       us_stall5;
    logic       ds_valid5;
    logic [7:0] d5_out;
    logic       stall5;
    logic       flush5;
    logic [2:0] count5;
    logic       af5;
    logic [2:0] max5;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vs_fifo #(.WIDTH(8), .DEPTH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .us_valid    (us_valid),
        .us_data     (us_data),
        .us_stall    (us_stall),
        .ds_valid    (ds_valid),
        .ds_data     (ds_data),
        .ds_stall    (ds_stall),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full),
        .max_count   (max_count)
    );

    vs_fifo #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .us_valid    (v5),
        .us_data     (d5_in),
        .us_stall    (us_stall5),
        .ds_valid    (ds_valid5),
        .ds_data     (d5_out),
        .ds_stall    (stall5),
        .flush       (flush5),
        .count       (count5),
        .almost_full (af5),
        .max_count   (max5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int wraps;
        logic p5;
        logic q5;

        rst = 1'b0; us_valid = 1'b1; us_data = 8'hAA; ds_stall = 1'b1; flush = 1'b0;
        v5 = 1'b0; d5_in = '0; stall5 = 1'b1; flush5 = 1'b0;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_ds_valid", ds_valid, 0);
        chk("rst_ds_data", ds_data, 0);
        chk("rst_us_stall", us_stall, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_max_count", max_count, 0);
        us_valid = 1'b0;
        rst = 1'b1;
        step();

        // Fill with downstream stalled
        for (int i = 1; i <= 6; i++) begin
            us_valid = 1'b1; us_data = 8'(i);
            #1;
            chk("fill_us_stall", us_stall, 0);
            step();
            chk("fill_count", count, 32'(i));
            chk("fill_af", almost_full, (i >= 4) ? 1 : 0);
            chk("fill_head", ds_data, 1);
        end
        us_data = 8'd7;
        #1;
        chk("full_us_stall", us_stall, 1);
        step();
        chk("full_count", count, 6);
        chk("full_max", max_count, 6);
        us_valid = 1'b0;

        // Drain in order
        ds_stall = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("drain_valid", ds_valid, 1);
            chk("drain_data", ds_data, 32'(i));
            step();
        end
        chk("drained_valid", ds_valid, 0);
        chk("drained_data", ds_data, 0);
        chk("drained_count", count, 0);
        chk("drained_max", max_count, 6);

        // Simultaneous push/pop at occupancy 3
        ds_stall = 1'b1; us_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            us_data = 8'(10 + i);
            step();
        end
        chk("mid_count", count, 3);
        ds_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            us_data = 8'(13 + k);
            #1;
            chk("both_head", ds_data, 32'(10 + k));
            step();
            chk("both_count", count, 3);
        end
        us_valid = 1'b0; ds_stall = 1'b1;

        // Full with pop: push refused that cycle, accepted the next
        us_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            us_data = 8'(23 + i);
            step();
        end
        chk("fp_count_full", count, 6);
        ds_stall = 1'b0; us_data = 8'd26;
        #1;
        chk("fp_us_stall", us_stall, 1);
        chk("fp_head", ds_data, 20);
        step();
        chk("fp_count_pop", count, 5);
        chk("fp_us_stall_next", us_stall, 0);
        step();
        chk("fp_count_both", count, 5);
        chk("fp_head_next", ds_data, 22);
        us_valid = 1'b0; ds_stall = 1'b1;

        // Flush from count=4, max_count=5
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush0_count", count, 0);
        chk("flush0_max", max_count, 0);
        us_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            us_data = 8'(30 + i);
            step();
        end
        us_valid = 1'b0; ds_stall = 1'b0;
        step();
        ds_stall = 1'b1;
        chk("preflush_count", count, 4);
        chk("preflush_max", max_count, 5);
        flush = 1'b1; us_valid = 1'b1; us_data = 8'd99; ds_stall = 1'b0;
        step();
        flush = 1'b0; us_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", ds_valid, 0);
        chk("flush_max", max_count, 0);
        step();
        chk("flush_dropped_count", count, 0);
        ds_stall = 1'b1; us_valid = 1'b1; us_data = 8'd40;
        step();
        chk("postflush_head", ds_data, 40);

        // Asynchronous reset mid-operation
        us_data = 8'd41; step();
        us_data = 8'd42; step();
        us_valid = 1'b0;
        chk("prerst_count", count, 3);
        rst = 1'b0;
        #1;
        chk("arst_valid", ds_valid, 0);
        chk("arst_data", ds_data, 0);
        chk("arst_count", count, 0);
        step();
        rst = 1'b1;
        us_valid = 1'b1; us_data = 8'd50; step();
        us_data = 8'd51; step();
        us_valid = 1'b0; ds_stall = 1'b0;
        chk("postrst_first", ds_data, 50);
        step();
        chk("postrst_second", ds_data, 51);
        step();
        chk("postrst_empty", ds_valid, 0);

        // DEPTH=5 stream with random downstream stalls
        sent = 0; recv = 0; wraps = 0;
        for (int cyc = 0; cyc < 400 && recv < 23; cyc++) begin
            v5 = (sent < 23);
            d5_in = 8'(sent + 1);
            stall5 = 1'($urandom_range(0, 1));
            #1;
            p5 = v5 && !us_stall5;
            q5 = ds_valid5 && !stall5;
            if (q5) begin
                chk("stream_data", d5_out, 32'(recv + 1));
                recv++;
            end
            if (p5) begin
                sent++;
                if (sent % 5 == 0) wraps++;
            end
            @(posedge clk);
            #1;
        end
        v5 = 1'b0;
        chk("stream_recv", recv, 23);
        chk("stream_wraps_ge4", (wraps >= 4) ? 1 : 0, 1);
        chk("stream_count", count5, 0);
        chk("stream_valid", ds_valid5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
